// File: rtl/circle_fill.sv
// Midpoint circle rasteriser: emits screen-space outline points or filled horizontal spans.
// One output per valid&&oe cycle, a fixed 2-cycle bubble between steps, and outputs are held while oe is low.
module circle_fill #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    oe,
  input  logic                    fill,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] r0,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic signed [CORDW-1:0] x_end,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);
  localparam int EW = CORDW + 2;

  typedef enum logic [1:0] {IDLE, EMIT, CALC_Y, CALC_X} state_t;

  state_t                  state, state_nxt;
  logic signed [EW-1:0]    xa, ya, err, err_tmp;
  logic signed [EW-1:0]    xa_nxt, ya_nxt, err_nxt, err_tmp_nxt;
  logic signed [EW-1:0]    r_ext, ya_inc, xa_inc;
  logic signed [CORDW-1:0] cx, cy, cx_nxt, cy_nxt;
  logic signed [CORDW-1:0] ox, oy, oxe, xs, ys;
  logic [1:0]              idx, idx_nxt;
  logic                    fill_r, fill_nxt, single, single_nxt;
  logic                    busy_nxt, done_nxt, last, xa_step;

  assign r_ext   = {{2{r0[CORDW-1]}}, r0};
  assign ya_inc  = ya + EW'(1);
  assign xa_inc  = xa + EW'(1);
  assign last    = single || (idx == 2'd3);
  assign xa_step = (err_tmp > xa) || (err > ya);
  assign valid   = (state == EMIT);

  always_comb begin
    state_nxt   = state;
    xa_nxt      = xa;
    ya_nxt      = ya;
    err_nxt     = err;
    err_tmp_nxt = err_tmp;
    idx_nxt     = idx;
    cx_nxt      = cx;
    cy_nxt      = cy;
    fill_nxt    = fill_r;
    single_nxt  = single;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        // The done cycle still counts as part of the previous draw.
        if (start && !done) begin
          cx_nxt   = x0;
          cy_nxt   = y0;
          fill_nxt = fill;
          if (r0[CORDW-1]) begin
            done_nxt = 1'b1;
          end else begin
            xa_nxt     = -r_ext;
            ya_nxt     = '0;
            err_nxt    = EW'(2) - (r_ext <<< 1);
            idx_nxt    = 2'd0;
            single_nxt = (r0 == '0);
            busy_nxt   = 1'b1;
            state_nxt  = EMIT;
          end
        end
      end
      EMIT: begin
        if (oe) begin
          if (last && single) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (last) begin
            state_nxt = CALC_Y;
          end else if (fill_r && idx == 2'd0 && ya == '0) begin
            idx_nxt = 2'd2;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      CALC_Y: begin
        err_tmp_nxt = err;
        if (err <= ya) begin
          ya_nxt  = ya_inc;
          err_nxt = err + (ya_inc <<< 1) + EW'(1);
        end
        state_nxt = CALC_X;
      end
      CALC_X: begin
        if (xa_step) begin
          xa_nxt  = xa_inc;
          err_nxt = err + (xa_inc <<< 1) + EW'(1);
        end
        if ((xa_step ? xa_inc : xa) == '0) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt   = 2'd0;
          state_nxt = EMIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output for the step/index about to be presented; coordinates wrap at CORDW bits.
  always_comb begin
    xs  = xa_nxt[CORDW-1:0];
    ys  = ya_nxt[CORDW-1:0];
    ox  = cx_nxt;
    oy  = cy_nxt;
    oxe = cx_nxt;
    if (fill_nxt) begin
      case (idx_nxt)
        2'd0: begin ox = cx_nxt + xs; oxe = cx_nxt - xs; oy = cy_nxt + ys; end
        2'd1: begin ox = cx_nxt + xs; oxe = cx_nxt - xs; oy = cy_nxt - ys; end
        2'd2: begin ox = cx_nxt - ys; oxe = cx_nxt + ys; oy = cy_nxt - xs; end
        2'd3: begin ox = cx_nxt - ys; oxe = cx_nxt + ys; oy = cy_nxt + xs; end
        default: ;
      endcase
    end else begin
      case (idx_nxt)
        2'd0: begin ox = cx_nxt - xs; oy = cy_nxt + ys; end
        2'd1: begin ox = cx_nxt - ys; oy = cy_nxt - xs; end
        2'd2: begin ox = cx_nxt + xs; oy = cy_nxt - ys; end
        2'd3: begin ox = cx_nxt + ys; oy = cy_nxt + xs; end
        default: ;
      endcase
      oxe = ox;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      xa      <= '0;
      ya      <= '0;
      err     <= '0;
      err_tmp <= '0;
      idx     <= '0;
      cx      <= '0;
      cy      <= '0;
      fill_r  <= 1'b0;
      single  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      x       <= '0;
      y       <= '0;
      x_end   <= '0;
    end else begin
      state   <= state_nxt;
      xa      <= xa_nxt;
      ya      <= ya_nxt;
      err     <= err_nxt;
      err_tmp <= err_tmp_nxt;
      idx     <= idx_nxt;
      cx      <= cx_nxt;
      cy      <= cy_nxt;
      fill_r  <= fill_nxt;
      single  <= single_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      if (state_nxt == EMIT) begin
        x     <= ox;
        y     <= oy;
        x_end <= oxe;
      end
    end
  end
endmodule

// File: tb/tb_circle_fill.sv
// Directed bench for circle_fill: 16-bit instance for the main scenarios, 8-bit instance for wrap/restart.
module tb_circle_fill;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start16 = 0, oe16 = 1, fill16 = 0;
  logic signed [15:0] x0_16 = 0, y0_16 = 0, r0_16 = 0;
  logic signed [15:0] x16, y16, xe16;
  logic               valid16, busy16, done16;

  logic               start8 = 0, oe8 = 1, fill8 = 0;
  logic signed [7:0]  x0_8 = 0, y0_8 = 0, r0_8 = 0;
  logic signed [7:0]  x8, y8, xe8;
  logic               valid8, busy8, done8;

  circle_fill #(.CORDW(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .oe(oe16), .fill(fill16),
    .x0(x0_16), .y0(y0_16), .r0(r0_16), .x(x16), .y(y16), .x_end(xe16),
    .valid(valid16), .busy(busy16), .done(done16));

  circle_fill #(.CORDW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .oe(oe8), .fill(fill8),
    .x0(x0_8), .y0(y0_8), .r0(r0_8), .x(x8), .y(y8), .x_end(xe8),
    .valid(valid8), .busy(busy8), .done(done8));

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  logic [47:0] q16[$], eq16[$];
  logic [23:0] q8[$], eq8[$];
  int done_seen16 = 0, done_cyc16 = 0, acc_cyc16 = 0, first_vld16 = -1, start_cyc16 = 0;
  int done_seen8 = 0;
  int overlap = 0, unstable = 0;
  logic        prev_hold16 = 0;
  logic [47:0] prev_out16 = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] p16(input int px, input int py, input int pe);
    return {16'(px), 16'(py), 16'(pe)};
  endfunction

  function automatic logic [23:0] p8(input int px, input int py);
    return {8'(px), 8'(py), 8'(px)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid16 && oe16) begin
      q16.push_back({x16, y16, xe16});
      acc_cyc16 = cyc;
    end
    if (valid16 && first_vld16 < 0) first_vld16 = cyc;
    if (done16) begin
      done_seen16 = 1;
      done_cyc16 = cyc;
    end
    if (valid8 && oe8) q8.push_back({x8, y8, xe8});
    if (done8) done_seen8 = 1;
    if ((busy16 && done16) || (busy8 && done8)) overlap++;
    if (rst_n && prev_hold16 && (!valid16 || {x16, y16, xe16} != prev_out16)) unstable++;
    prev_hold16 = rst_n && valid16 && !oe16;
    prev_out16  = {x16, y16, xe16};
  end

  task automatic run16(input logic f, input int cx, input int cy, input int r, input bit rnd);
    q16.delete();
    done_seen16 = 0;
    first_vld16 = -1;
    @(posedge clk); #1;
    fill16 = f; x0_16 = 16'(cx); y0_16 = 16'(cy); r0_16 = 16'(r);
    oe16 = 1; start16 = 1; start_cyc16 = cyc;
    @(posedge clk); #1;
    start16 = 0;
    for (int i = 0; i < 300 && done_seen16 == 0; i++) begin
      if (rnd) oe16 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    oe16 = 1;
    chk("done16_seen", 64'(done_seen16), 64'd1);
  endtask

  task automatic cmp16(input string tag);
    chk({tag, "_count"}, 64'(q16.size()), 64'(eq16.size()));
    for (int i = 0; i < eq16.size() && i < q16.size(); i++)
      chk($sformatf("%s_out%0d", tag, i), 64'(q16[i]), 64'(eq16[i]));
  endtask

  task automatic load_r2;
    eq16.delete();
    eq16.push_back(p16( 2, 0, 2));  eq16.push_back(p16( 0, 2, 0));
    eq16.push_back(p16(-2, 0,-2));  eq16.push_back(p16( 0,-2, 0));
    eq16.push_back(p16( 2, 1, 2));  eq16.push_back(p16(-1, 2,-1));
    eq16.push_back(p16(-2,-1,-2));  eq16.push_back(p16( 1,-2, 1));
    eq16.push_back(p16( 1, 2, 1));  eq16.push_back(p16(-2, 1,-2));
    eq16.push_back(p16(-1,-2,-1));  eq16.push_back(p16( 2,-1, 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int dups;
    #1;
    chk("rst_valid", 64'(valid16), 64'd0);
    chk("rst_busy",  64'(busy16),  64'd0);
    chk("rst_done",  64'(done16),  64'd0);
    chk("rst_xy",    64'({x16, y16, xe16}), 64'd0);
    #21 rst_n = 1;

    // Reset mid-draw with the output stalled
    done_seen16 = 0;
    @(posedge clk); #1;
    fill16 = 0; x0_16 = 0; y0_16 = 0; r0_16 = 2; oe16 = 0; start16 = 1;
    @(posedge clk); #1;
    start16 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("s1_valid_held", 64'(valid16), 64'd1);
    chk("s1_busy",       64'(busy16),  64'd1);
    chk("s1_x_held",     64'(x16),     64'd2);
    #2 rst_n = 0;
    #1;
    chk("s1_rst_valid", 64'(valid16), 64'd0);
    chk("s1_rst_busy",  64'(busy16),  64'd0);
    chk("s1_rst_done",  64'(done16),  64'd0);
    chk("s1_rst_xy",    64'({x16, y16, xe16}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1; oe16 = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("s1_no_done", 64'(done_seen16), 64'd0);
    chk("s1_idle",    64'(valid16),     64'd0);

    // Outline r0=1 at (10,20)
    eq16.delete();
    eq16.push_back(p16(11, 20, 11)); eq16.push_back(p16(10, 21, 10));
    eq16.push_back(p16( 9, 20,  9)); eq16.push_back(p16(10, 19, 10));
    run16(0, 10, 20, 1, 0);
    cmp16("s2");
    chk("s2_first_lat", 64'(first_vld16 - start_cyc16), 64'd1);
    chk("s2_done_lat",  64'(done_cyc16 - acc_cyc16),    64'd3);

    // Outline r0=2 at origin
    load_r2();
    run16(0, 0, 0, 2, 0);
    cmp16("s3");
    dups = 0;
    for (int i = 0; i < q16.size(); i++)
      for (int j = i + 1; j < q16.size(); j++)
        if (q16[i] == q16[j]) dups++;
    chk("s3_dups", 64'(dups), 64'd0);

    // Fill r0=1 at (10,20): idx1 span skipped on the ya==0 row
    eq16.delete();
    eq16.push_back(p16( 9, 20, 11));
    eq16.push_back(p16(10, 21, 10));
    eq16.push_back(p16(10, 19, 10));
    run16(1, 10, 20, 1, 0);
    cmp16("s4");

    // Random backpressure on r0=2 outline
    load_r2();
    unstable = 0;
    run16(0, 0, 0, 2, 1);
    cmp16("s5_bp");
    chk("s5_stable", 64'(unstable), 64'd0);

    // r0=0 and r0<0
    eq16.delete();
    eq16.push_back(p16(5, -7, 5));
    run16(0, 5, -7, 0, 0);
    cmp16("s5_r0");
    eq16.delete();
    run16(0, 1, 1, -3, 0);
    cmp16("s5_neg");
    chk("s5_neg_done_lat", 64'(done_cyc16 - start_cyc16), 64'd1);

    // 8-bit wrap with starts injected while busy
    eq8.delete();
    eq8.push_back(p8(-127, 0)); eq8.push_back(p8(126, 3));  eq8.push_back(p8(123, 0));  eq8.push_back(p8(126, -3));
    eq8.push_back(p8(-127, 1)); eq8.push_back(p8(125, 3));  eq8.push_back(p8(123, -1)); eq8.push_back(p8(127, -3));
    eq8.push_back(p8(-128, 2)); eq8.push_back(p8(124, 2));  eq8.push_back(p8(124, -2)); eq8.push_back(p8(-128, -2));
    eq8.push_back(p8(127, 3));  eq8.push_back(p8(123, 1));  eq8.push_back(p8(125, -3)); eq8.push_back(p8(-127, -1));
    q8.delete();
    done_seen8 = 0;
    @(posedge clk); #1;
    fill8 = 0; x0_8 = 126; y0_8 = 0; r0_8 = 3; oe8 = 1; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    for (int i = 0; i < 300 && done_seen8 == 0; i++) begin
      start8 = (i == 4 || i == 9);
      x0_8 = start8 ? 8'sd0 : 8'sd126;
      r0_8 = start8 ? 8'sd5 : 8'sd3;
      @(posedge clk); #1;
    end
    start8 = 0;
    chk("s6_done_seen", 64'(done_seen8), 64'd1);
    chk("s6_count", 64'(q8.size()), 64'(eq8.size()));
    for (int i = 0; i < eq8.size() && i < q8.size(); i++)
      chk($sformatf("s6_out%0d", i), 64'(q8[i]), 64'(eq8[i]));
    chk("s6_busy_idle", 64'(busy8), 64'd0);

    chk("busy_done_overlap", 64'(overlap), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
